// File: rtl/wb_ram_burst.sv
// Wishbone B4 slave RAM with programmable wait states, out-of-range err and
// optional registered-feedback CTI/BTE bursts (compiled in by WB_RAM_BURST_EN).
module wb_ram_burst #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned LATENCY    = 0,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  sel,
  input  logic        we,
  input  logic        cyc,
  input  logic        stb,
  input  logic [2:0]  cti,
  input  logic [1:0]  bte,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err
);
  localparam int unsigned WORD_BITS = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH     = 1 << WORD_BITS;
  localparam logic [2:0]  LAT       = 3'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BEAT  = 2'd2,
    S_BURST = 2'd3
  } state_t;

  logic [31:0]          mem [DEPTH];
  state_t               state;
  logic [29:0]          waddr;
  logic                 lwe;
  logic [2:0]           cnt;
  logic                 beat;
  logic                 in_range;
  logic [WORD_BITS-1:0] idx;

  // Full 30-bit word address is kept so a linear burst running off the top is caught.
  assign in_range = ((waddr >> WORD_BITS) == '0);
  assign idx      = waddr[WORD_BITS-1:0];
  assign beat     = cyc && ((state == S_BEAT) || ((state == S_BURST) && stb));

`ifdef WB_RAM_BURST_EN
  logic [2:0]  lcti;
  logic [1:0]  lbte;
  logic [29:0] next_addr;
  logic        burst_req;
  logic        unused_bits;

  assign unused_bits = ^addr[1:0];
  assign burst_req   = (lcti == 3'b001) || (lcti == 3'b010);

  always_comb begin
    next_addr = waddr + 30'd1;
    if (lcti == 3'b001) begin
      next_addr = waddr;
    end else begin
      case (lbte)
        2'b01:   next_addr = {waddr[29:2], waddr[1:0] + 2'd1};
        2'b10:   next_addr = {waddr[29:3], waddr[2:0] + 3'd1};
        2'b11:   next_addr = {waddr[29:4], waddr[3:0] + 4'd1};
        default: ;
      endcase
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], cti, bte};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      waddr <= '0;
      lwe   <= 1'b0;
      cnt   <= '0;
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
`ifdef WB_RAM_BURST_EN
      lcti  <= '0;
      lbte  <= '0;
`endif
    end else begin
      ack   <= beat && in_range;
      err   <= beat && !in_range;
      rdata <= (beat && in_range) ? mem[idx] : '0;
      case (state)
        S_IDLE: begin
          if (cyc && stb) begin
            waddr <= addr[31:2];
            lwe   <= we;
            cnt   <= LAT;
`ifdef WB_RAM_BURST_EN
            lcti  <= cti;
            lbte  <= bte;
`endif
            state <= (LATENCY > 0) ? S_WAIT : S_BEAT;
          end
        end
        S_WAIT: begin
          if (!cyc) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1) state <= S_BEAT;
          end
        end
        S_BEAT: begin
          state <= S_IDLE;
`ifdef WB_RAM_BURST_EN
          if (cyc && in_range && burst_req) begin
            state <= S_BURST;
            waddr <= next_addr;
          end
`endif
        end
`ifdef WB_RAM_BURST_EN
        S_BURST: begin
          if (!cyc) begin
            state <= S_IDLE;
          end else if (stb) begin
            waddr <= next_addr;
            if (!in_range || (cti == 3'b111)) state <= S_IDLE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // The array is never reset; old data is returned on a same-beat read/write.
  always_ff @(posedge clk) begin
    if (beat && in_range && lwe) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (sel[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_ram_burst.sv
// Directed bench for wb_ram_burst: a LATENCY=0 and a LATENCY=3 instance share
// the bus inputs but each has its own cyc line.
module tb_wb_ram_burst;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;
  logic        we, cyc0, cyc3, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] rdata0, rdata3;
  logic        ack0, err0, ack3, err3;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  wb_ram_burst #(.ADDR_WIDTH(14), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .sel(sel), .we(we),
    .cyc(cyc0), .stb(stb), .cti(cti), .bte(bte),
    .rdata(rdata0), .ack(ack0), .err(err0)
  );

  wb_ram_burst #(.ADDR_WIDTH(14), .LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .sel(sel), .we(we),
    .cyc(cyc3), .stb(stb), .cti(cti), .bte(bte),
    .rdata(rdata3), .ack(ack3), .err(err3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Classic transfer; lat = cycles from the sampling edge to the ack/err edge, -1 on timeout.
  task automatic xfer(input bit slow, input logic [31:0] a, input logic w,
                      input logic [31:0] d, input logic [3:0] s,
                      output int lat, output logic [31:0] rd,
                      output logic e, output logic a_seen);
    addr = a; we = w; wdata = d; sel = s; cti = 3'b000; bte = 2'b00; stb = 1'b1;
    if (slow) cyc3 = 1'b1; else cyc0 = 1'b1;
    lat = -1; rd = '0; e = 1'b0; a_seen = 1'b0;
    tick;
    for (int i = 1; i <= 12; i++) begin
      tick;
      if (slow ? (ack3 || err3) : (ack0 || err0)) begin
        lat    = i;
        rd     = slow ? rdata3 : rdata0;
        e      = slow ? err3 : err0;
        a_seen = slow ? ack3 : ack0;
        break;
      end
    end
    cyc0 = 1'b0; cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset;
    logic bad;
    reset = 1'b1;
    repeat (3) tick;
    checks++;
    if (ack0 !== 1'b0 || err0 !== 1'b0 || rdata0 !== 32'h0) begin
      errors++;
      $display("FAIL reset_dut0: ack=%b err=%b rdata=%h expected 0 0 00000000", ack0, err0, rdata0);
    end
    checks++;
    if (ack3 !== 1'b0 || err3 !== 1'b0 || rdata3 !== 32'h0) begin
      errors++;
      $display("FAIL reset_dut3: ack=%b err=%b rdata=%h expected 0 0 00000000", ack3, err3, rdata3);
    end
    reset = 1'b0;
    stb = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      tick;
      if (ack0 || err0 || ack3 || err3) bad = 1'b1;
    end
    stb = 1'b0;
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_cyc: response seen=%b expected 0", bad);
    end
  endtask

  task automatic test_masked_write;
    int lat; logic [31:0] rd; logic e, a;
    xfer(0, 32'h100, 1'b1, 32'h0, 4'hF, lat, rd, e, a);
    xfer(0, 32'h100, 1'b1, 32'hDEADBEEF, 4'b0101, lat, rd, e, a);
    checks++;
    if (lat !== 1 || a !== 1'b1) begin
      errors++;
      $display("FAIL masked_write_lat: lat=%0d ack=%b expected 1 1", lat, a);
    end
    xfer(0, 32'h100, 1'b0, 32'h0, 4'hF, lat, rd, e, a);
    checks++;
    if (rd !== 32'h00AD00EF || lat !== 1) begin
      errors++;
      $display("FAIL masked_read: rdata=%h lat=%0d expected 00ad00ef 1", rd, lat);
    end
    tick;
    checks++;
    if (ack0 !== 1'b0) begin
      errors++;
      $display("FAIL ack_pulse0: ack=%b expected 0", ack0);
    end
    xfer(0, 32'h101, 1'b1, 32'h12345678, 4'b1010, lat, rd, e, a);
    xfer(0, 32'h100, 1'b0, 32'h0, 4'hF, lat, rd, e, a);
    checks++;
    if (rd !== 32'h12AD56EF) begin
      errors++;
      $display("FAIL masked_read2: rdata=%h expected 12ad56ef", rd);
    end
  endtask

  task automatic test_wait_states;
    int lat; logic [31:0] rd; logic e, a, bad;
    xfer(1, 32'h40, 1'b1, 32'hCAFEF00D, 4'hF, lat, rd, e, a);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL wait_write_lat: lat=%0d expected 4", lat);
    end
    xfer(1, 32'h40, 1'b0, 32'h0, 4'hF, lat, rd, e, a);
    checks++;
    if (lat !== 4 || rd !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL wait_read: lat=%0d rdata=%h expected 4 cafef00d", lat, rd);
    end
    tick;
    checks++;
    if (ack3 !== 1'b0) begin
      errors++;
      $display("FAIL ack_pulse3: ack=%b expected 0", ack3);
    end
    xfer(1, 32'h44, 1'b1, 32'h11111111, 4'hF, lat, rd, e, a);
    addr = 32'h44; we = 1'b1; wdata = 32'h22222222; sel = 4'hF; cyc3 = 1'b1; stb = 1'b1;
    repeat (3) tick;
    cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      tick;
      if (ack3 || err3) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL wait_abort_ack: response seen=%b expected 0", bad);
    end
    xfer(1, 32'h44, 1'b0, 32'h0, 4'hF, lat, rd, e, a);
    checks++;
    if (rd !== 32'h11111111) begin
      errors++;
      $display("FAIL wait_abort_nowrite: rdata=%h expected 11111111", rd);
    end
  endtask

  task automatic test_out_of_range;
    int lat; logic [31:0] rd; logic e, a;
    xfer(0, 32'h0, 1'b1, 32'hA5A5A5A5, 4'hF, lat, rd, e, a);
    xfer(0, 32'h4000, 1'b1, 32'hFFFFFFFF, 4'hF, lat, rd, e, a);
    checks++;
    if (e !== 1'b1 || a !== 1'b0 || lat !== 1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL oor_write: err=%b ack=%b lat=%0d rdata=%h expected 1 0 1 00000000", e, a, lat, rd);
    end
    xfer(0, 32'h0, 1'b0, 32'h0, 4'hF, lat, rd, e, a);
    checks++;
    if (rd !== 32'hA5A5A5A5 || e !== 1'b0) begin
      errors++;
      $display("FAIL oor_nowrite: rdata=%h err=%b expected a5a5a5a5 0", rd, e);
    end
    xfer(0, 32'hFFFFFFFC, 1'b0, 32'h0, 4'hF, lat, rd, e, a);
    checks++;
    if (e !== 1'b1 || a !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL oor_read_top: err=%b ack=%b rdata=%h expected 1 0 00000000", e, a, rd);
    end
  endtask

`ifdef WB_RAM_BURST_EN
  task automatic test_wrap_burst;
    int lat; logic [31:0] rd; logic e, a;
    logic [31:0] exp_a [4];
    exp_a = '{32'h18, 32'h1C, 32'h10, 32'h14};
    for (int k = 0; k < 4; k++)
      xfer(0, 32'h10 + 32'(4 * k), 1'b1, 32'hB0000010 + 32'(4 * k), 4'hF, lat, rd, e, a);
    addr = 32'h18; we = 1'b0; sel = 4'hF; cti = 3'b010; bte = 2'b01; cyc0 = 1'b1; stb = 1'b1;
    tick;
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++;
      if (ack0 !== 1'b1 || rdata0 !== (32'hB0000000 | exp_a[k])) begin
        errors++;
        $display("FAIL wrap4_beat%0d: ack=%b rdata=%h expected 1 %h", k, ack0, rdata0,
                 32'hB0000000 | exp_a[k]);
      end
      addr = 32'h0;
      if (k == 2) cti = 3'b111;
    end
    addr = 32'h100; cti = 3'b000; bte = 2'b00;
    tick;
    checks++;
    if (ack0 !== 1'b0) begin
      errors++;
      $display("FAIL wrap4_idle_gap: ack=%b expected 0", ack0);
    end
    tick;
    checks++;
    if (ack0 !== 1'b1 || rdata0 !== 32'h12AD56EF) begin
      errors++;
      $display("FAIL wrap4_next_classic: ack=%b rdata=%h expected 1 12ad56ef", ack0, rdata0);
    end
    cyc0 = 1'b0; stb = 1'b0;
    tick;
  endtask

  task automatic test_linear_overflow;
    int lat; logic [31:0] rd; logic e, a;
    xfer(0, 32'h3FF8, 1'b1, 32'h000000E1, 4'hF, lat, rd, e, a);
    xfer(0, 32'h3FFC, 1'b1, 32'h000000E2, 4'hF, lat, rd, e, a);
    addr = 32'h3FF8; we = 1'b0; cti = 3'b010; bte = 2'b00; cyc0 = 1'b1; stb = 1'b1;
    tick;
    tick;
    checks++;
    if (ack0 !== 1'b1 || rdata0 !== 32'hE1) begin
      errors++;
      $display("FAIL lin_top_beat0: ack=%b rdata=%h expected 1 000000e1", ack0, rdata0);
    end
    tick;
    checks++;
    if (ack0 !== 1'b1 || rdata0 !== 32'hE2) begin
      errors++;
      $display("FAIL lin_top_beat1: ack=%b rdata=%h expected 1 000000e2", ack0, rdata0);
    end
    tick;
    checks++;
    if (err0 !== 1'b1 || ack0 !== 1'b0 || rdata0 !== 32'h0) begin
      errors++;
      $display("FAIL lin_top_err: err=%b ack=%b rdata=%h expected 1 0 00000000", err0, ack0, rdata0);
    end
    cyc0 = 1'b0; stb = 1'b0; cti = 3'b000;
    tick;
  endtask

  task automatic test_stall_abort;
    int lat; logic [31:0] rd; logic e, a, bad;
    xfer(0, 32'h208, 1'b1, 32'h0, 4'hF, lat, rd, e, a);
    xfer(0, 32'h20C, 1'b1, 32'h0, 4'hF, lat, rd, e, a);
    addr = 32'h200; we = 1'b1; wdata = 32'h11110000; sel = 4'hF;
    cti = 3'b010; bte = 2'b00; cyc0 = 1'b1; stb = 1'b1;
    tick;
    tick;
    wdata = 32'h22220001;
    tick;
    checks++;
    if (ack0 !== 1'b1) begin
      errors++;
      $display("FAIL stall_beat1: ack=%b expected 1", ack0);
    end
    stb = 1'b0;
    bad = 1'b0;
    repeat (2) begin
      tick;
      if (ack0 || err0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL stall_no_ack: response seen=%b expected 0", bad);
    end
    stb = 1'b1; wdata = 32'h33330002;
    tick;
    checks++;
    if (ack0 !== 1'b1) begin
      errors++;
      $display("FAIL stall_resume: ack=%b expected 1", ack0);
    end
    cyc0 = 1'b0; wdata = 32'hFFFFFFFF;
    bad = 1'b0;
    repeat (2) begin
      tick;
      if (ack0 || err0) bad = 1'b1;
    end
    stb = 1'b0; we = 1'b0; cti = 3'b000;
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_ack: response seen=%b expected 0", bad);
    end
    xfer(0, 32'h204, 1'b0, 32'h0, 4'hF, lat, rd, e, a);
    checks++;
    if (rd !== 32'h22220001 || lat !== 1) begin
      errors++;
      $display("FAIL stall_word1: rdata=%h lat=%0d expected 22220001 1", rd, lat);
    end
    xfer(0, 32'h208, 1'b0, 32'h0, 4'hF, lat, rd, e, a);
    checks++;
    if (rd !== 32'h33330002) begin
      errors++;
      $display("FAIL stall_word2: rdata=%h expected 33330002", rd);
    end
    xfer(0, 32'h20C, 1'b0, 32'h0, 4'hF, lat, rd, e, a);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL stall_word3: rdata=%h expected 00000000", rd);
    end
  endtask
`else
  task automatic test_burst_classic;
    int lat, n; logic [31:0] rd; logic e, a;
    for (int k = 0; k < 4; k++)
      xfer(0, 32'h10 + 32'(4 * k), 1'b1, 32'hB0000010 + 32'(4 * k), 4'hF, lat, rd, e, a);
    we = 1'b0; sel = 4'hF; bte = 2'b00; cyc0 = 1'b1; stb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      addr = 32'h10 + 32'(4 * k);
      cti  = (k == 3) ? 3'b111 : 3'b010;
      n = 0;
      for (int t = 1; t <= 8; t++) begin
        tick;
        if (ack0) begin
          n = t;
          break;
        end
      end
      checks++;
      if (n !== 2 || rdata0 !== (32'hB0000010 + 32'(4 * k))) begin
        errors++;
        $display("FAIL classic_burst_beat%0d: cycles=%0d rdata=%h expected 2 %h", k, n, rdata0,
                 32'hB0000010 + 32'(4 * k));
      end
    end
    cyc0 = 1'b0; stb = 1'b0; cti = 3'b000;
    tick;
    checks++;
    if (ack0 !== 1'b0) begin
      errors++;
      $display("FAIL classic_burst_end: ack=%b expected 0", ack0);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; addr = '0; wdata = '0; sel = '0; we = 1'b0;
    cyc0 = 1'b0; cyc3 = 1'b0; stb = 1'b0; cti = '0; bte = '0;
    test_reset;
    test_masked_write;
    test_wait_states;
    test_out_of_range;
`ifdef WB_RAM_BURST_EN
    test_wrap_burst;
    test_linear_overflow;
    test_stall_abort;
`else
    test_burst_classic;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
